bcd_time_counter: RTL

- Time-of-day keeper for the digital clock: six BCD digits (hh:mm:ss), advanced by a 1 Hz enable pulse.
- Sits downstream of the divider's 1 Hz tick and upstream of the display mux/decoder.
- Each field is a BCD units digit plus a BCD tens digit, using the same +1 and >9 correction rule as the BCD adder, bounded per field.
- Includes a user set mode: select a field, then increment it.

---
 rtl/bcd_time_counter_if.sv | 25 ++
 rtl/bcd_time_counter.sv | 116 +++++++++++
 2 files changed

// File: rtl/bcd_time_counter_if.sv
// Control pulses in and BCD time/status out for the hh:mm:ss keeper.
// The master side drives the pulses and the slave side (the counter) drives the time.
interface bcd_time_counter_if;
  logic       tick;
  logic       set_mode;
  logic       sel_pulse;
  logic       inc_pulse;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       pm;
  logic [1:0] field_sel;
  logic       day_carry;
  logic       setting;

  modport master (
    output tick, set_mode, sel_pulse, inc_pulse,
    input  sec_bcd, min_bcd, hour_bcd, pm, field_sel, day_carry, setting
  );

  modport slave (
    input  tick, set_mode, sel_pulse, inc_pulse,
    output sec_bcd, min_bcd, hour_bcd, pm, field_sel, day_carry, setting
  );
endinterface

// File: rtl/bcd_time_counter.sv
// Six-digit BCD time of day advanced by a 1 Hz tick, with a SET mode
// that picks a field and bumps it without carrying into its neighbour.
module bcd_time_counter #(
  parameter bit HOURS_24 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_time_counter_if.slave bus
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_SET = 1'b1;
  localparam logic [7:0] HOUR_RST = HOURS_24 ? 8'h00 : 8'h12;

  logic [0:0] state_q, state_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hour_q, hour_d;
  logic       pm_q, pm_d;
  logic [1:0] field_sel_q, field_sel_d;
  logic       day_carry_q, day_carry_d;

  logic       sec_wrap, min_wrap, day_wrap;
  logic [7:0] sec_nx, min_nx, hour_nx;
  logic       pm_nx;

  function automatic logic [7:0] bcd_step(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_step = {v[7:4] + 4'd1, 4'd0};
    else                bcd_step = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Per-field successors; shared by the RUN carry chain and the SET increment.
  always_comb begin
    sec_wrap = (sec_q == 8'h59);
    min_wrap = (min_q == 8'h59);
    sec_nx   = sec_wrap ? 8'h00 : bcd_step(sec_q);
    min_nx   = min_wrap ? 8'h00 : bcd_step(min_q);
    if (HOURS_24) begin
      day_wrap = (hour_q == 8'h23);
      hour_nx  = day_wrap ? 8'h00 : bcd_step(hour_q);
      pm_nx    = 1'b0;
    end else begin
      day_wrap = (hour_q == 8'h11) && pm_q;
      hour_nx  = (hour_q == 8'h12) ? 8'h01 : bcd_step(hour_q);
      pm_nx    = (hour_q == 8'h11) ? ~pm_q : pm_q;
    end
  end

  always_comb begin
    state_d     = bus.set_mode ? ST_SET : ST_RUN;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    pm_d        = pm_q;
    field_sel_d = field_sel_q;
    day_carry_d = 1'b0;

    if (state_q == ST_RUN) begin
      if (bus.tick) begin
        sec_d = sec_nx;
        if (sec_wrap) begin
          min_d = min_nx;
          if (min_wrap) begin
            hour_d      = hour_nx;
            pm_d        = pm_nx;
            day_carry_d = day_wrap;
          end
        end
      end
      if (bus.set_mode) field_sel_d = 2'd0;
    end else begin
      // Increment uses the field selected before any same-cycle sel_pulse.
      if (bus.inc_pulse) begin
        case (field_sel_q)
          2'd0:    sec_d = sec_nx;
          2'd1:    min_d = min_nx;
          2'd2: begin
            hour_d = hour_nx;
            pm_d   = pm_nx;
          end
          default: ;
        endcase
      end
      if (bus.sel_pulse) field_sel_d = (field_sel_q == 2'd2) ? 2'd0 : field_sel_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= HOUR_RST;
      pm_q        <= 1'b0;
      field_sel_q <= 2'd0;
      day_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      pm_q        <= pm_d;
      field_sel_q <= field_sel_d;
      day_carry_q <= day_carry_d;
    end
  end

  assign bus.sec_bcd   = sec_q;
  assign bus.min_bcd   = min_q;
  assign bus.hour_bcd  = hour_q;
  assign bus.pm        = pm_q;
  assign bus.field_sel = field_sel_q;
  assign bus.day_carry = day_carry_q;
  assign bus.setting   = (state_q == ST_SET);

endmodule
